// File: rtl/regfile_wb_arbiter_if.sv
// ---------------------------------------------------------------------------
// regfile_wb_arbiter_if
//
// Purpose: bundles every bus-side signal of the register-file writeback
// arbiter. This covers the three writeback request channels, the issue-side
// scoreboard interface and the register-file write port.
//
// Parameters:
//   DATA_W  writeback data width
//   ADDR_W  register address width (2**ADDR_W registers)
//
// Signals (directions given from the arbiter's point of view, modport slave):
//   alu_valid/alu_addr/alu_data  in   ALU writeback request
//   alu_ready                    out  ALU request accepted this cycle
//   mem_valid/mem_addr/mem_data  in   load-unit writeback request
//   mem_ready                    out  load-unit request accepted this cycle
//   mdu_valid/mdu_addr/mdu_data  in   multiply/divide writeback request
//   mdu_ready                    out  multiply/divide request accepted
//   issue_valid/issue_addr       in   issued instruction with destination
//   pending                      out  per-register outstanding-write bits
//   wb_we/wb_addr/wb_data        out  register-file RegWrite/WriteAddr/Data
//
// Modports: master = requesters/issue logic/register file side,
//           slave  = arbiter.
// ---------------------------------------------------------------------------
interface regfile_wb_arbiter_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
);
    localparam int unsigned NUM_REGS = 1 << ADDR_W;

    logic                alu_valid;
    logic [ADDR_W-1:0]   alu_addr;
    logic [DATA_W-1:0]   alu_data;
    logic                alu_ready;

    logic                mem_valid;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_data;
    logic                mem_ready;

    logic                mdu_valid;
    logic [ADDR_W-1:0]   mdu_addr;
    logic [DATA_W-1:0]   mdu_data;
    logic                mdu_ready;

    logic                issue_valid;
    logic [ADDR_W-1:0]   issue_addr;
    logic [NUM_REGS-1:0] pending;

    logic                wb_we;
    logic [ADDR_W-1:0]   wb_addr;
    logic [DATA_W-1:0]   wb_data;

    modport master (
        output alu_valid, alu_addr, alu_data,
        input  alu_ready,
        output mem_valid, mem_addr, mem_data,
        input  mem_ready,
        output mdu_valid, mdu_addr, mdu_data,
        input  mdu_ready,
        output issue_valid, issue_addr,
        input  pending,
        input  wb_we, wb_addr, wb_data
    );

    modport slave (
        input  alu_valid, alu_addr, alu_data,
        output alu_ready,
        input  mem_valid, mem_addr, mem_data,
        output mem_ready,
        input  mdu_valid, mdu_addr, mdu_data,
        output mdu_ready,
        input  issue_valid, issue_addr,
        output pending,
        output wb_we, wb_addr, wb_data
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_wb_arbiter
//
// Purpose: shares the register file's single write port between the ALU,
// the load unit (MEM) and the multiply/divide unit (MDU). Each cycle at most
// one valid request is granted, and the grant is signalled by that source's
// ready. The accepted write is presented to the register file one cycle
// later on registered wb_we/wb_addr/wb_data. A pending-write scoreboard
// tracks destinations that have been issued but not yet written back.
//
// Ports:
//   clk      in  system clock, rising edge
//   reset_n  in  asynchronous active-low reset
//   bus      regfile_wb_arbiter_if.slave: request channels, issue/pending
//            scoreboard port and register-file write port
//
// Configuration macro:
//   WB_ALU_PRIO_EN  when defined, the ALU has fixed highest priority and
//                   MEM/MDU round-robin between themselves using a 2-way
//                   pointer that ALU grants do not move. When undefined,
//                   all three sources share one 3-way round-robin in the
//                   order ALU -> MEM -> MDU -> ALU.
//
// Writes to register 0 are accepted but never reach the register file, and
// pending[0] is held at 0.
// ---------------------------------------------------------------------------
module regfile_wb_arbiter #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
) (
    input  logic                 clk,
    input  logic                 reset_n,
    regfile_wb_arbiter_if.slave  bus
);

    localparam int unsigned NUM_REGS = 1 << ADDR_W;

    // Round-robin pointer: names the source with highest priority this cycle.
    typedef enum logic [1:0] {
        SRC_ALU = 2'd0,
        SRC_MEM = 2'd1,
        SRC_MDU = 2'd2
    } src_e;

`ifdef WB_ALU_PRIO_EN
    // Only MEM and MDU rotate; the ALU sits outside the rotation.
    localparam src_e PTR_RESET = SRC_MEM;
`else
    localparam src_e PTR_RESET = SRC_ALU;
`endif

    src_e                rr_ptr;
    src_e                rr_ptr_next;

    logic                gnt_alu;
    logic                gnt_mem;
    logic                gnt_mdu;
    logic                xfer;

    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_data;

    logic                wb_we_q;
    logic [ADDR_W-1:0]   wb_addr_q;
    logic [DATA_W-1:0]   wb_data_q;

    logic [NUM_REGS-1:0] pending_q;
    logic [NUM_REGS-1:0] pending_next;

    // -----------------------------------------------------------------------
    // Arbiter state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr <= PTR_RESET;
        end else begin
            rr_ptr <= rr_ptr_next;
        end
    end

    // -----------------------------------------------------------------------
    // Arbiter next-state: the pointer moves just past the granted source and
    // holds when nothing is granted.
    // -----------------------------------------------------------------------
    always_comb begin
        rr_ptr_next = rr_ptr;
`ifdef WB_ALU_PRIO_EN
        if (gnt_mem) begin
            rr_ptr_next = SRC_MDU;
        end else if (gnt_mdu) begin
            rr_ptr_next = SRC_MEM;
        end
`else
        if (gnt_alu) begin
            rr_ptr_next = SRC_MEM;
        end else if (gnt_mem) begin
            rr_ptr_next = SRC_MDU;
        end else if (gnt_mdu) begin
            rr_ptr_next = SRC_ALU;
        end
`endif
    end

    // -----------------------------------------------------------------------
    // Arbiter outputs: grants depend only on valids and the pointer, never on
    // ready. They are forced low while reset is asserted.
    // -----------------------------------------------------------------------
    always_comb begin
        gnt_alu = 1'b0;
        gnt_mem = 1'b0;
        gnt_mdu = 1'b0;
        if (reset_n) begin
`ifdef WB_ALU_PRIO_EN
            if (bus.alu_valid) begin
                gnt_alu = 1'b1;
            end else if (rr_ptr == SRC_MDU) begin
                if (bus.mdu_valid) begin
                    gnt_mdu = 1'b1;
                end else if (bus.mem_valid) begin
                    gnt_mem = 1'b1;
                end
            end else begin
                if (bus.mem_valid) begin
                    gnt_mem = 1'b1;
                end else if (bus.mdu_valid) begin
                    gnt_mdu = 1'b1;
                end
            end
`else
            case (rr_ptr)
                SRC_MEM: begin
                    if (bus.mem_valid) begin
                        gnt_mem = 1'b1;
                    end else if (bus.mdu_valid) begin
                        gnt_mdu = 1'b1;
                    end else if (bus.alu_valid) begin
                        gnt_alu = 1'b1;
                    end
                end
                SRC_MDU: begin
                    if (bus.mdu_valid) begin
                        gnt_mdu = 1'b1;
                    end else if (bus.alu_valid) begin
                        gnt_alu = 1'b1;
                    end else if (bus.mem_valid) begin
                        gnt_mem = 1'b1;
                    end
                end
                default: begin
                    if (bus.alu_valid) begin
                        gnt_alu = 1'b1;
                    end else if (bus.mem_valid) begin
                        gnt_mem = 1'b1;
                    end else if (bus.mdu_valid) begin
                        gnt_mdu = 1'b1;
                    end
                end
            endcase
`endif
        end
    end

    assign bus.alu_ready = gnt_alu;
    assign bus.mem_ready = gnt_mem;
    assign bus.mdu_ready = gnt_mdu;

    assign xfer = gnt_alu | gnt_mem | gnt_mdu;

    // -----------------------------------------------------------------------
    // Granted request mux
    // -----------------------------------------------------------------------
    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        if (gnt_alu) begin
            sel_addr = bus.alu_addr;
            sel_data = bus.alu_data;
        end else if (gnt_mem) begin
            sel_addr = bus.mem_addr;
            sel_data = bus.mem_data;
        end else if (gnt_mdu) begin
            sel_addr = bus.mdu_addr;
            sel_data = bus.mdu_data;
        end
    end

    // -----------------------------------------------------------------------
    // Register-file write port: one-cycle latency. Address and data hold
    // between transfers, and a transfer to register 0 loads them but leaves
    // the write enable low.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wb_we_q   <= 1'b0;
            wb_addr_q <= '0;
            wb_data_q <= '0;
        end else begin
            wb_we_q <= xfer && (sel_addr != '0);
            if (xfer) begin
                wb_addr_q <= sel_addr;
                wb_data_q <= sel_data;
            end
        end
    end

    assign bus.wb_we   = wb_we_q;
    assign bus.wb_addr = wb_addr_q;
    assign bus.wb_data = wb_data_q;

    // -----------------------------------------------------------------------
    // Pending-write scoreboard. The set is applied after the clear, so a
    // same-cycle issue to a register being written back leaves the bit set.
    // The issue is the younger of the two operations. Bit 0 is forced clear.
    // -----------------------------------------------------------------------
    always_comb begin
        pending_next = pending_q;
        if (xfer) begin
            pending_next[sel_addr] = 1'b0;
        end
        if (bus.issue_valid) begin
            pending_next[bus.issue_addr] = 1'b1;
        end
        pending_next[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_next;
        end
    end

    assign bus.pending = pending_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_regfile_wb_arbiter
//
// Directed bench for regfile_wb_arbiter. Inputs change 1 time unit after the
// rising edge. Ready is checked once the inputs have settled, and registered
// outputs are checked 1 time unit after the edge that loads them.
// The WB_ALU_PRIO_EN build replaces the 3-way fairness sequence with the
// fixed-ALU-priority sequence.
// ---------------------------------------------------------------------------
module tb_regfile_wb_arbiter;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 5;

    logic clk;
    logic reset_n;

    int checks;
    int failures;

    regfile_wb_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    regfile_wb_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks   = 0;
        failures = 0;

        reset_n         = 1'b0;
        bus.alu_valid   = 1'b0;
        bus.alu_addr    = '0;
        bus.alu_data    = '0;
        bus.mem_valid   = 1'b1;
        bus.mem_addr    = 5'd6;
        bus.mem_data    = 32'h66;
        bus.mdu_valid   = 1'b0;
        bus.mdu_addr    = '0;
        bus.mdu_data    = '0;
        bus.issue_valid = 1'b0;
        bus.issue_addr  = '0;

        // Reset state, with a valid request that must not be readied.
        tick();
        tick();
        chk("rst_wb_we",     bus.wb_we,     0);
        chk("rst_wb_addr",   bus.wb_addr,   0);
        chk("rst_wb_data",   bus.wb_data,   0);
        chk("rst_pending",   bus.pending,   0);
        chk("rst_mem_ready", bus.mem_ready, 0);
        bus.mem_valid = 1'b0;
        reset_n       = 1'b1;

        // Contention from pointer = ALU: grants ALU, MEM, MDU back to back.
        bus.alu_valid = 1'b1; bus.alu_addr = 5'd3; bus.alu_data = 32'h11;
        bus.mem_valid = 1'b1; bus.mem_addr = 5'd4; bus.mem_data = 32'h22;
        bus.mdu_valid = 1'b1; bus.mdu_addr = 5'd5; bus.mdu_data = 32'h33;
        #1;
        chk("ct_alu_ready1", bus.alu_ready, 1);
        chk("ct_mem_ready1", bus.mem_ready, 0);
        chk("ct_mdu_ready1", bus.mdu_ready, 0);
        tick();
        bus.alu_valid = 1'b0;
        chk("ct_wb_we1",   bus.wb_we,   1);
        chk("ct_wb_addr1", bus.wb_addr, 3);
        chk("ct_wb_data1", bus.wb_data, 32'h11);
        #1;
        chk("ct_mem_ready2", bus.mem_ready, 1);
        chk("ct_mdu_ready2", bus.mdu_ready, 0);
        tick();
        bus.mem_valid = 1'b0;
        chk("ct_wb_we2",   bus.wb_we,   1);
        chk("ct_wb_addr2", bus.wb_addr, 4);
        chk("ct_wb_data2", bus.wb_data, 32'h22);
        #1;
        chk("ct_mdu_ready3", bus.mdu_ready, 1);
        tick();
        bus.mdu_valid = 1'b0;
        chk("ct_wb_we3",   bus.wb_we,   1);
        chk("ct_wb_addr3", bus.wb_addr, 5);
        chk("ct_wb_data3", bus.wb_data, 32'h33);
        tick();
        chk("ct_idle_we",   bus.wb_we,   0);
        chk("ct_idle_addr", bus.wb_addr, 5);
        chk("ct_idle_data", bus.wb_data, 32'h33);

`ifndef WB_ALU_PRIO_EN
        // Fairness: ALU always valid, MDU valid. Grants alternate ALU, MDU.
        bus.alu_valid = 1'b1; bus.alu_addr = 5'd1; bus.alu_data = 32'hA1;
        bus.mdu_valid = 1'b1; bus.mdu_addr = 5'd7; bus.mdu_data = 32'h77;
        #1;
        chk("fr_alu_ready1", bus.alu_ready, 1);
        chk("fr_mdu_ready1", bus.mdu_ready, 0);
        tick();
        chk("fr_wb_addr1", bus.wb_addr, 1);
        #1;
        chk("fr_mdu_ready2", bus.mdu_ready, 1);
        chk("fr_alu_ready2", bus.alu_ready, 0);
        tick();
        bus.mdu_addr = 5'd8; bus.mdu_data = 32'h88;
        chk("fr_wb_we2",   bus.wb_we,   1);
        chk("fr_wb_addr2", bus.wb_addr, 7);
        chk("fr_wb_data2", bus.wb_data, 32'h77);
        #1;
        chk("fr_alu_ready3", bus.alu_ready, 1);
        chk("fr_mdu_ready3", bus.mdu_ready, 0);
        tick();
        chk("fr_wb_addr3", bus.wb_addr, 1);
        #1;
        chk("fr_mdu_ready4", bus.mdu_ready, 1);
        tick();
        bus.alu_valid = 1'b0;
        bus.mdu_valid = 1'b0;
        chk("fr_wb_addr4", bus.wb_addr, 8);
        chk("fr_wb_data4", bus.wb_data, 32'h88);
        tick();
        chk("fr_idle_we", bus.wb_we, 0);
`else
        // Fixed ALU priority: ALU wins for 4 cycles, then MEM, then MDU.
        bus.alu_valid = 1'b1; bus.alu_addr = 5'd1; bus.alu_data = 32'hA1;
        bus.mem_valid = 1'b1; bus.mem_addr = 5'd4; bus.mem_data = 32'h44;
        bus.mdu_valid = 1'b1; bus.mdu_addr = 5'd5; bus.mdu_data = 32'h55;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("pr_alu_ready", bus.alu_ready, 1);
            chk("pr_mem_ready", bus.mem_ready, 0);
            chk("pr_mdu_ready", bus.mdu_ready, 0);
            tick();
            chk("pr_wb_addr_alu", bus.wb_addr, 1);
        end
        bus.alu_valid = 1'b0;
        #1;
        chk("pr_mem_ready_after", bus.mem_ready, 1);
        tick();
        bus.mem_valid = 1'b0;
        chk("pr_wb_addr_mem", bus.wb_addr, 4);
        #1;
        chk("pr_mdu_ready_after", bus.mdu_ready, 1);
        tick();
        bus.mdu_valid = 1'b0;
        chk("pr_wb_addr_mdu", bus.wb_addr, 5);
        tick();
        chk("pr_idle_we", bus.wb_we, 0);
`endif

        // Scoreboard set, clear by writeback, then set-wins on collision.
        bus.issue_valid = 1'b1; bus.issue_addr = 5'd9;
        tick();
        bus.issue_valid = 1'b0;
        chk("sb_set", bus.pending, 32'h200);
        bus.mem_valid = 1'b1; bus.mem_addr = 5'd9; bus.mem_data = 32'h99;
        #1;
        chk("sb_mem_ready", bus.mem_ready, 1);
        tick();
        bus.mem_valid = 1'b0;
        chk("sb_clr_we",      bus.wb_we,   1);
        chk("sb_clr_addr",    bus.wb_addr, 9);
        chk("sb_clr_pending", bus.pending, 0);
        bus.issue_valid = 1'b1; bus.issue_addr = 5'd9;
        tick();
        bus.issue_valid = 1'b0;
        chk("sb_reset", bus.pending, 32'h200);
        bus.issue_valid = 1'b1; bus.issue_addr = 5'd9;
        bus.mem_valid = 1'b1; bus.mem_addr = 5'd9; bus.mem_data = 32'h9A;
        #1;
        chk("sb_col_ready", bus.mem_ready, 1);
        tick();
        bus.issue_valid = 1'b0;
        bus.mem_valid   = 1'b0;
        chk("sb_col_we",      bus.wb_we,   1);
        chk("sb_col_pending", bus.pending, 32'h200);

        // Register 0: accepted, no write, scoreboard unchanged.
        bus.mdu_valid = 1'b1; bus.mdu_addr = 5'd0; bus.mdu_data = 32'hDEAD;
        #1;
        chk("z_mdu_ready", bus.mdu_ready, 1);
        tick();
        bus.mdu_valid = 1'b0;
        chk("z_wb_we",   bus.wb_we,   0);
        chk("z_wb_data", bus.wb_data, 32'hDEAD);
        chk("z_pending", bus.pending, 32'h200);
        bus.issue_valid = 1'b1; bus.issue_addr = 5'd0;
        tick();
        bus.issue_valid = 1'b0;
        chk("z_issue_pending", bus.pending, 32'h200);

        // Clear register 9 through the ALU.
        bus.alu_valid = 1'b1; bus.alu_addr = 5'd9; bus.alu_data = 32'h5;
        #1;
        chk("cl_alu_ready", bus.alu_ready, 1);
        tick();
        bus.alu_valid = 1'b0;
        chk("cl_wb_we",   bus.wb_we,   1);
        chk("cl_pending", bus.pending, 0);

        // Reset in the middle of a transfer with MEM still requesting.
        bus.issue_valid = 1'b1; bus.issue_addr = 5'd13;
        bus.mem_valid = 1'b1; bus.mem_addr = 5'd12; bus.mem_data = 32'hC;
        tick();
        bus.issue_valid = 1'b0;
        chk("mr_pre_we",      bus.wb_we,   1);
        chk("mr_pre_pending", bus.pending, 32'h2000);
        reset_n = 1'b0;
        #1;
        chk("mr_wb_we",     bus.wb_we,     0);
        chk("mr_wb_addr",   bus.wb_addr,   0);
        chk("mr_pending",   bus.pending,   0);
        chk("mr_mem_ready", bus.mem_ready, 0);
        tick();
        reset_n = 1'b1;
        #1;
        chk("mr_post_mem_ready", bus.mem_ready, 1);
        chk("mr_post_alu_ready", bus.alu_ready, 0);
        tick();
        bus.mem_valid = 1'b0;
        chk("mr_post_we",   bus.wb_we,   1);
        chk("mr_post_addr", bus.wb_addr, 12);
        chk("mr_post_data", bus.wb_data, 32'hC);
        tick();
        chk("mr_idle_we", bus.wb_we, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
Shares the register file's single write port among three writeback sources: ALU, load unit (MEM) and multiply/divide unit (MDU). Grants one source per cycle using round-robin arbitration with a valid/ready handshake. Drives registered RegWrite/WriteAddr/WriteData into the register file. Keeps a 32-bit pending-write scoreboard that issue logic uses for hazard stalls.

Parameters:
DATA_W, 32, writeback data width
ADDR_W, 5, register address width (32 registers)

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
alu_valid  input  1  ALU writeback request
alu_addr  input  ADDR_W  ALU destination register
alu_data  input  DATA_W  ALU result
alu_ready  output  1  ALU request accepted this cycle
mem_valid / mem_addr / mem_data / mem_ready  same as alu_*, load unit
mdu_valid / mdu_addr / mdu_data / mdu_ready  same as alu_*, multiply/divide unit
issue_valid  input  1  instruction issued with destination register
issue_addr  input  ADDR_W  destination of issued instruction
pending  output  32  bit r = 1 while a write to r is outstanding
wb_we  output  1  to register file RegWrite
wb_addr  output  ADDR_W  to register file WriteAddr
wb_data  output  DATA_W  to register file WriteData

Behaviour:
- Reset (async, reset_n=0): wb_we=0, wb_addr=0, wb_data=0, pending=0, rr pointer=ALU. All readys low while in reset.
- Handshake: transfer when X_valid && X_ready on a rising edge. Requester holds valid/addr/data stable until accepted. At most one ready high per cycle. Ready is combinational from valids and the rr pointer, with no dependency on ready.
- Round-robin: pointer p names the highest-priority source; order ALU->MEM->MDU->ALU. Grant the first valid source starting at p. After a grant to source k, p <= k+1 mod 3. With no grant, p is held.
- Output: registered, 1-cycle latency. On the edge a transfer occurs: wb_we<=1 (0 if addr==0), wb_addr<=addr, wb_data<=data. With no transfer: wb_we<=0, and wb_addr/wb_data hold their values.
- Address 0: the request is accepted (ready asserted) but produces no write. pending[0] is always 0.
- Scoreboard:
  - issue_valid with issue_addr!=0 sets pending[issue_addr] at the edge.
  - An accepted writeback clears pending[addr] at the same edge wb_we rises.
  - Set and clear of the same register in one cycle: set wins, because the new issue is younger.
  - Clearing an already-clear bit has no effect. Each issue expects exactly one writeback.
- Full throughput: one write per cycle when any source is valid. No bubbles between back-to-back grants.
- Reset mid-transfer: the in-flight output is dropped and wb_we goes to 0 immediately. Requesters must re-present after reset.

Optional Feature:
WB_ALU_PRIO_EN: when defined, ALU has fixed highest priority (alu_valid always granted), and MEM/MDU round-robin between themselves with a 2-way pointer that ALU grants do not update. When undefined, all three sources share the 3-way round-robin described above.

Test Plan:
- Reset: reset_n low mid-run with mem_valid=1 -> wb_we=0, pending=0, all readys 0. After release, the first grant goes to MEM when it is the only valid source.
- Contention: alu/mem/mdu all valid with addrs 3/4/5, data 0x11/0x22/0x33, held until accepted -> grants ALU, MEM, MDU on consecutive cycles. wb_addr sequence 3,4,5 one cycle later. wb_we high for 3 cycles.
- Fairness: ALU valid continuously, MDU valid with addr 7 -> MDU granted within 2 cycles. Alternating grants ALU, MDU, ALU, ...
- Scoreboard: issue addr 9 -> pending=0x200. MEM writeback to addr 9 -> pending bit 9 clears on the wb_we=1 cycle. Same-cycle issue 9 and writeback 9 -> pending[9] stays 1.
- Zero register: mdu_valid, addr 0, data 0xDEAD -> mdu_ready=1, wb_we stays 0, pending unchanged. Issue addr 0 -> pending[0]=0.
- WB_ALU_PRIO_EN defined: all three sources valid for 4 cycles (ALU continuously) -> only ALU granted. After ALU drops, MEM then MDU are granted.
